// File: rtl/mic_sample_ram_writer.sv
// mic_sample_ram_writer
// Packs pairs of 16-bit mic samples into 32-bit words and writes them to
// RAM port 2 as a two-half ping-pong buffer.  Each half raises a sticky
// ready flag (and irq) when full; software clears it with ack[i].
// Optional build macro: MIC_WRITER_OVERRUN_CNT_EN adds the overrun_count
// port and its saturating dropped-sample counter.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | capture disabled, pointer and pack register cleared
// FILL  | packing samples and writing words at wptr
// DROP  | target half still owned by software; samples are discarded

module mic_sample_ram_writer #(
    parameter int ADDR_W   = 7,
    parameter int SAMPLE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [SAMPLE_W-1:0]   snk_data,
    input  logic                  snk_valid,
    output logic                  snk_ready,
    output logic [ADDR_W-1:0]     address2,
    output logic                  chipselect2,
    output logic                  write2,
    output logic [3:0]            byteenable2,
    output logic [2*SAMPLE_W-1:0] writedata2,
    output logic                  clken2,
    output logic [1:0]            half_ready,
    input  logic [1:0]            ack,
    output logic                  irq
`ifdef MIC_WRITER_OVERRUN_CNT_EN
    ,
    output logic [15:0]           overrun_count
`endif
);

    typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;

    state_t                state, state_nxt;
    logic                  phase, phase_nxt;
    logic [SAMPLE_W-1:0]   low_sample, low_nxt;
    logic [ADDR_W-1:0]     wptr, wptr_nxt;
    logic                  drop_half, drop_half_nxt;
    logic                  write_nxt;
    logic [ADDR_W-1:0]     addr_nxt;
    logic [2*SAMPLE_W-1:0] wdata_nxt;
    logic [1:0]            set_hr;
    logic [1:0]            hr_after_ack;
    logic                  accept;
    logic                  resume;
    logic                  next_half;

    assign snk_ready    = enable && (state != IDLE);
    assign accept       = snk_valid && snk_ready;
    assign hr_after_ack = half_ready & ~ack;
    assign resume       = !half_ready[drop_half] && !phase;
    assign next_half    = ~wptr[ADDR_W-1];
    assign chipselect2  = write2;
    assign byteenable2  = 4'hF;
    assign clken2       = 1'b1;
    assign irq          = |half_ready;

    // Next-state, packing and RAM-write decisions
    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        low_nxt       = low_sample;
        wptr_nxt      = wptr;
        drop_half_nxt = drop_half;
        write_nxt     = 1'b0;
        addr_nxt      = address2;
        wdata_nxt     = writedata2;
        set_hr        = 2'b00;
        case (state)
            IDLE: begin
                phase_nxt = 1'b0;
                wptr_nxt  = '0;
                low_nxt   = '0;
                if (enable) begin
                    if (half_ready[0]) begin
                        state_nxt     = DROP;
                        drop_half_nxt = 1'b0;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    phase_nxt = 1'b0;
                end else if (accept) begin
                    if (!phase) begin
                        low_nxt   = snk_data;
                        phase_nxt = 1'b1;
                    end else begin
                        write_nxt = 1'b1;
                        addr_nxt  = wptr;
                        wdata_nxt = {snk_data, low_sample};
                        wptr_nxt  = wptr + ADDR_W'(1);
                        phase_nxt = 1'b0;
                        // Last word of a half: flag it and check the next half is free
                        if (&wptr[ADDR_W-2:0]) begin
                            set_hr[wptr[ADDR_W-1]] = 1'b1;
                            if (hr_after_ack[next_half]) begin
                                state_nxt     = DROP;
                                drop_half_nxt = next_half;
                            end
                        end
                    end
                end
            end
            DROP: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    phase_nxt = 1'b0;
                end else if (resume) begin
                    // Half released on a pair boundary: this sample starts a new word
                    state_nxt = FILL;
                    wptr_nxt  = {drop_half, {(ADDR_W-1){1'b0}}};
                    if (accept) begin
                        low_nxt   = snk_data;
                        phase_nxt = 1'b1;
                    end
                end else if (accept) begin
                    phase_nxt = ~phase;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered RAM-port outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= 1'b0;
            low_sample <= '0;
            wptr       <= '0;
            drop_half  <= 1'b0;
            half_ready <= 2'b00;
            write2     <= 1'b0;
            address2   <= '0;
            writedata2 <= '0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            low_sample <= low_nxt;
            wptr       <= wptr_nxt;
            drop_half  <= drop_half_nxt;
            half_ready <= hr_after_ack | set_hr;
            write2     <= write_nxt;
            address2   <= addr_nxt;
            writedata2 <= wdata_nxt;
        end
    end

`ifdef MIC_WRITER_OVERRUN_CNT_EN
    logic drop_sample;
    assign drop_sample = (state == DROP) && accept && !resume;

    // Saturating count of discarded samples; held across enable changes
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_count <= '0;
        end else if (drop_sample && (overrun_count != 16'hFFFF)) begin
            overrun_count <= overrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mic_sample_ram_writer.sv
// Testbench for mic_sample_ram_writer: scoreboard of expected RAM writes,
// pushed when the second sample of a pair is driven and popped when write2
// is observed.  Honours MIC_WRITER_OVERRUN_CNT_EN if defined.

module tb_mic_sample_ram_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] snk_data;
    logic        snk_valid;
    logic        snk_ready;
    logic [6:0]  address2;
    logic        chipselect2;
    logic        write2;
    logic [3:0]  byteenable2;
    logic [31:0] writedata2;
    logic        clken2;
    logic [1:0]  half_ready;
    logic [1:0]  ack;
    logic        irq;
`ifdef MIC_WRITER_OVERRUN_CNT_EN
    logic [15:0] overrun_count;
`endif

    mic_sample_ram_writer dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .snk_data    (snk_data),
        .snk_valid   (snk_valid),
        .snk_ready   (snk_ready),
        .address2    (address2),
        .chipselect2 (chipselect2),
        .write2      (write2),
        .byteenable2 (byteenable2),
        .writedata2  (writedata2),
        .clken2      (clken2),
        .half_ready  (half_ready),
        .ack         (ack),
        .irq         (irq)
`ifdef MIC_WRITER_OVERRUN_CNT_EN
        ,
        .overrun_count (overrun_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
        bit          chk_hr;
        logic [1:0]  hr;
    } wr_t;

    wr_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  wr_count = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Pop the scoreboard on each observed write
    always @(negedge clk) begin
        if (write2 === 1'b1) begin
            wr_count++;
            check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                wr_t e;
                e = sb_q.pop_front();
                check("wr_addr", 32'(address2), 32'(e.addr));
                check("wr_data", writedata2, e.data);
                check("wr_cs", 32'(chipselect2), 32'd1);
                if (e.chk_hr) begin
                    check("hr_at_last", 32'(half_ready), 32'(e.hr));
                    check("irq_at_last", 32'(irq), 32'd1);
                end
            end
        end
    end

    task automatic drive(input logic [15:0] d, input logic [1:0] a);
        @(negedge clk);
        snk_valid = 1'b1;
        snk_data  = d;
        ack       = a;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            snk_valid = 1'b0;
            ack       = 2'b00;
        end
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic [6:0] addr,
                             input bit chk, input logic [1:0] hr, input logic [1:0] ack_last);
        wr_t e;
        drive(a, 2'b00);
        drive(b, ack_last);
        e.addr = addr; e.data = {b, a}; e.chk_hr = chk; e.hr = hr;
        sb_q.push_back(e);
    endtask

    // Fill word addresses lo..hi with consecutive samples starting at base
    task automatic fill(input logic [15:0] base, input int lo, input int hi,
                        input logic [1:0] hr_last, input logic [1:0] ack_last);
        for (int k = lo; k <= hi; k++) begin
            logic [15:0] s;
            s = base + 16'(2 * (k - lo));
            send_pair(s, s + 16'd1, 7'(k), (k == hi), hr_last,
                      (k == hi) ? ack_last : 2'b00);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_snk_ready"}, 32'(snk_ready), 32'd0);
        check({pfx, "_address2"}, 32'(address2), 32'd0);
        check({pfx, "_cs2"}, 32'(chipselect2), 32'd0);
        check({pfx, "_write2"}, 32'(write2), 32'd0);
        check({pfx, "_wdata2"}, writedata2, 32'd0);
        check({pfx, "_be2"}, 32'(byteenable2), 32'hF);
        check({pfx, "_clken2"}, 32'(clken2), 32'd1);
        check({pfx, "_half_ready"}, 32'(half_ready), 32'd0);
        check({pfx, "_irq"}, 32'(irq), 32'd0);
`ifdef MIC_WRITER_OVERRUN_CNT_EN
        check({pfx, "_overrun"}, 32'(overrun_count), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; snk_valid = 1'b0; snk_data = '0; ack = 2'b00;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;

        // snk_ready rises one cycle after enable
        enable = 1'b1;
        #1 check("ready_same_cycle", 32'(snk_ready), 32'd0);
        @(negedge clk);
        check("ready_next_cycle", 32'(snk_ready), 32'd1);

        // Half 0 then half 1 with samples 0x0001 upward
        fill(16'h0001, 0, 63, 2'b01, 2'b00);
        fill(16'h0081, 64, 127, 2'b11, 2'b00);

        // Both halves full: 10 samples dropped
        for (int i = 0; i < 10; i++) drive(16'h0500 + 16'(i), 2'b00);
        idle(3);
        check("wr_count_full", 32'(wr_count), 32'd128);
        check("hr_both", 32'(half_ready), 32'd3);
        check("irq_both", 32'(irq), 32'd1);
`ifdef MIC_WRITER_OVERRUN_CNT_EN
        check("overrun_10", 32'(overrun_count), 32'd10);
`endif

        // Release half 0; writes resume at address 0
        drive(16'h0000, 2'b01);
        snk_valid = 1'b0;
        idle(1);
        check("hr_after_ack0", 32'(half_ready), 32'd2);
        idle(2);
        send_pair(16'h1001, 16'h1002, 7'd0, 1'b0, 2'b00, 2'b00);
        drive(16'h0000, 2'b10);
        snk_valid = 1'b0;
        idle(1);
        check("hr_after_ack1", 32'(half_ready), 32'd0);
        fill(16'h1003, 1, 63, 2'b01, 2'b00);
        // ack[1] coincides with the last write of half 1: set wins
        fill(16'h2001, 64, 127, 2'b11, 2'b10);
        idle(3);
        check("hr_set_wins", 32'(half_ready), 32'd3);

        // Release both, write two words, then drop enable mid-pair
        drive(16'h0000, 2'b11);
        snk_valid = 1'b0;
        idle(3);
        send_pair(16'h3001, 16'h3002, 7'd0, 1'b0, 2'b00, 2'b00);
        send_pair(16'h3003, 16'h3004, 7'd1, 1'b0, 2'b00, 2'b00);
        drive(16'h3005, 2'b00);
        @(negedge clk);
        enable = 1'b0; snk_valid = 1'b0;
        idle(2);
        check("ready_after_disable", 32'(snk_ready), 32'd0);
        check("wr_count_disable", 32'(wr_count), 32'd258);
        enable = 1'b1;
        idle(2);
        send_pair(16'h4001, 16'h4002, 7'd0, 1'b0, 2'b00, 2'b00);
        idle(3);
        check("wr_count_reenable", 32'(wr_count), 32'd259);

        // Reset coincides with the edge that would launch write2
        drive(16'h5001, 2'b00);
        drive(16'h5002, 2'b00);
        reset = 1'b1; enable = 1'b0;
        @(negedge clk);
        snk_valid = 1'b0;
        check_reset_vals("midrst");
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("postrst");

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("wr_count_final", 32'(wr_count), 32'd259);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
